// File: rtl/pktmem_pkg.sv
// Shared types and sizes for the packet memory arbiter.
// Used by packet_memory_arbiter and pktmem_rr_grant.
package pktmem_pkg;

   localparam int PKTMEM_ADDR_W    = 10;
   localparam int PKTMEM_DATA_W    = 32;
   localparam int PKTMEM_BE_W      = PKTMEM_DATA_W / 8;
   localparam int PKTMEM_NUM_PORTS = 2;

   // Requester index: 0 = capture writer, 1 = Nios master
   typedef logic port_id_t;

   // One requester's view of a memory access
   typedef struct packed {
      logic [PKTMEM_ADDR_W-1:0] addr;
      logic [PKTMEM_BE_W-1:0]   be;
      logic                     read;
      logic                     write;
      logic [PKTMEM_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/pktmem_rr_grant.sv
// Two-requester grant logic for the packet memory.
// Round-robin by default. With PKTMEM_ARB_P0_PRIO_EN defined, port 0 has
// strict priority; last_grant is still tracked but only matters for
// round-robin contention.
module pktmem_rr_grant
   import pktmem_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [PKTMEM_NUM_PORTS-1:0] req,
   output logic                        gnt_any,
   output port_id_t                    gnt_port
);

   port_id_t last_grant;

   // Pick the winner for this cycle; nothing is granted while in reset
   always_comb begin
      gnt_any  = reset_n & (|req);
`ifdef PKTMEM_ARB_P0_PRIO_EN
      gnt_port = req[0] ? 1'b0 : 1'b1;
`else
      if (req[0] & req[1]) begin
         gnt_port = ~last_grant;
      end else begin
         gnt_port = req[0] ? 1'b0 : 1'b1;
      end
`endif
   end

   // Remember who was served last; reset value makes port 0 win first
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant <= 1'b1;
      end else if (gnt_any) begin
         last_grant <= gnt_port;
      end
   end

endmodule

// File: rtl/packet_memory_arbiter.sv
// Shares one single-port packet RAM (1-cycle read latency) between the
// capture writer (port 0) and the Nios master (port 1).
// Optional macro PKTMEM_ARB_P0_PRIO_EN: strict priority for port 0
// instead of round-robin (handled in pktmem_rr_grant).
module packet_memory_arbiter
   import pktmem_pkg::*;
#(
   parameter  int ADDR_W = PKTMEM_ADDR_W,
   parameter  int DATA_W = PKTMEM_DATA_W,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] p0_address,
   input  logic [BE_W-1:0]   p0_byteenable,
   input  logic              p0_read,
   input  logic              p0_write,
   input  logic [DATA_W-1:0] p0_writedata,
   output logic              p0_waitrequest,
   output logic [DATA_W-1:0] p0_readdata,
   output logic              p0_readdatavalid,
   input  logic [ADDR_W-1:0] p1_address,
   input  logic [BE_W-1:0]   p1_byteenable,
   input  logic              p1_read,
   input  logic              p1_write,
   input  logic [DATA_W-1:0] p1_writedata,
   output logic              p1_waitrequest,
   output logic [DATA_W-1:0] p1_readdata,
   output logic              p1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic              proto_err
);

   mem_req_t                    req0, req1, sel;
   logic [PKTMEM_NUM_PORTS-1:0] req;
   logic                        gnt_any;
   port_id_t                    gnt_port;
   logic                        sel_is_read;
   logic                        rd_pend;
   port_id_t                    rd_port;

   assign req0 = '{addr: p0_address, be: p0_byteenable, read: p0_read,
                   write: p0_write, wdata: p0_writedata};
   assign req1 = '{addr: p1_address, be: p1_byteenable, read: p1_read,
                   write: p1_write, wdata: p1_writedata};
   assign req  = {p1_read | p1_write, p0_read | p0_write};

   pktmem_rr_grant u_grant (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .gnt_any  (gnt_any),
      .gnt_port (gnt_port)
   );

   // Route the winning port to the RAM; idle bus parks at address 0
   always_comb begin
      sel            = gnt_port ? req1 : req0;
      mem_chipselect = gnt_any;
      mem_write      = gnt_any & sel.write;
      mem_address    = gnt_any ? sel.addr : '0;
      mem_byteenable = sel.be;
      mem_writedata  = sel.wdata;
      mem_clken      = 1'b1;
      // read+write together is executed as a write only
      sel_is_read    = gnt_any & sel.read & ~sel.write;
   end

   // Only the granted port sees waitrequest low; idle ports stay stalled
   always_comb begin
      p0_waitrequest = ~(gnt_any & (gnt_port == 1'b0));
      p1_waitrequest = ~(gnt_any & (gnt_port == 1'b1));
   end

   // Tag each accepted read so its data returns to the right port next cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_pend <= 1'b0;
         rd_port <= 1'b0;
      end else begin
         rd_pend <= sel_is_read;
         if (sel_is_read) begin
            rd_port <= gnt_port;
         end
      end
   end

   // Read return; reset masks a return that was already in flight
   always_comb begin
      p0_readdata      = mem_readdata;
      p1_readdata      = mem_readdata;
      p0_readdatavalid = reset_n & rd_pend & (rd_port == 1'b0);
      p1_readdatavalid = reset_n & rd_pend & (rd_port == 1'b1);
   end

   // Sticky flag: some master drove read and write in the same cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         proto_err <= 1'b0;
      end else if ((p0_read & p0_write) | (p1_read & p1_write)) begin
         proto_err <= 1'b1;
      end
   end

endmodule
